// File: rtl/sm_acc_arbiter_pkg.sv
// Shared constants and types for the sign-magnitude accumulation arbiter.
// Word layout: bit SIGN_IDX is the sign, bits MAG_W-1:0 the magnitude.
package sm_acc_arbiter_pkg;

    localparam int O_VEC    = 21;
    localparam int SIGN_IDX = O_VEC - 1;
    localparam int MAG_W    = O_VEC - 1;

    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/sm_acc_arbiter_if.sv
// Lane-side bundle: term requests and grants in, per-lane results out.
// master = lanes/consumer, slave = arbiter.
interface sm_acc_arbiter_if
    import sm_acc_arbiter_pkg::*;
#(
    parameter int NREQ = 4
);

    logic [NREQ-1:0]       req;
    logic [NREQ*O_VEC-1:0] term_data;
    logic [NREQ-1:0]       term_last;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       res_valid;
    logic [NREQ-1:0]       res_ready;
    logic [NREQ*O_VEC-1:0] res_data;
    logic [NREQ-1:0]       ovf;

    modport master (
        output req, term_data, term_last, res_ready,
        input  gnt, res_valid, res_data, ovf
    );

    modport slave (
        input  req, term_data, term_last, res_ready,
        output gnt, res_valid, res_data, ovf
    );

endinterface

// File: rtl/sm_acc_arbiter_add_unit.sv
// sm_add_unit: combinational sign-magnitude adder, zero normalized to +0.
// Ports: a_i, b_i operands; sum_o result; ovf_o saturation (SM_ACC_SAT_EN).
module sm_add_unit
    import sm_acc_arbiter_pkg::*;
(
    input  logic [O_VEC-1:0] a_i,
    input  logic [O_VEC-1:0] b_i,
    output logic [O_VEC-1:0] sum_o,
    output logic             ovf_o
);

    logic             sa;
    logic             sb;
    logic             s;
    logic [MAG_W-1:0] ma;
    logic [MAG_W-1:0] mb;
    logic [MAG_W-1:0] m;
`ifdef SM_ACC_SAT_EN
    logic [MAG_W:0]   wide;
`endif

    always_comb begin
        sa    = a_i[SIGN_IDX];
        sb    = b_i[SIGN_IDX];
        ma    = a_i[MAG_W-1:0];
        mb    = b_i[MAG_W-1:0];
        s     = sa;
        m     = '0;
        ovf_o = 1'b0;
`ifdef SM_ACC_SAT_EN
        wide  = '0;
`endif
        if (sa == sb) begin
`ifdef SM_ACC_SAT_EN
            wide = {1'b0, ma} + {1'b0, mb};
            // carry out of the magnitude clamps to full scale
            if (wide[MAG_W]) begin
                m     = MAG_MAX;
                ovf_o = 1'b1;
            end else begin
                m = wide[MAG_W-1:0];
            end
`else
            m = ma + mb;
`endif
        end else if (ma >= mb) begin
            m = ma - mb;
            s = sa;
        end else begin
            m = mb - ma;
            s = sb;
        end
        if (m == '0) begin
            s = 1'b0;
        end
        sum_o = {s, m};
    end

endmodule

// File: rtl/sm_acc_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude adder among NREQ lanes.
// Ports: clk, rst_n (async low), bus (slave). Option: SM_ACC_SAT_EN.
module sm_acc_arbiter
    import sm_acc_arbiter_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sm_acc_arbiter_if.slave   bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    lane_state_e      state_q [NREQ];
    lane_state_e      state_d [NREQ];
    logic [O_VEC-1:0] acc_q   [NREQ];
    logic [O_VEC-1:0] acc_d   [NREQ];
    logic [O_VEC-1:0] res_q   [NREQ];
    logic [O_VEC-1:0] res_d   [NREQ];
    logic [NREQ-1:0]  ovf_q;
    logic [NREQ-1:0]  ovf_d;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;

    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    pick;
    logic             found;
    logic [O_VEC-1:0] op_a;
    logic [O_VEC-1:0] op_b;
    logic             op_last;
    logic [O_VEC-1:0] sum;
    logic             sum_ovf;
    int               idx;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            elig[k] = bus.req[k] && (state_q[k] == ACCUM);
        end
    end

    // first eligible lane at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // gnt held low while reset is asserted
    always_comb begin
        gnt = '0;
        if (found && rst_n) begin
            gnt = NREQ'(1) << pick;
        end
    end

    always_comb begin
        op_a    = acc_q[pick];
        op_b    = bus.term_data[pick*O_VEC +: O_VEC];
        op_last = bus.term_last[pick];
    end

    sm_add_unit u_add (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (sum),
        .ovf_o (sum_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (state_q[k] == HOLD && bus.res_ready[k]) begin
                state_d[k] = ACCUM;
                ovf_d[k]   = 1'b0;
            end
        end
        if (found) begin
            ptr_d = (pick == PW'(NREQ - 1)) ? '0 : pick + 1'b1;
            if (op_last) begin
                res_d[pick]   = sum;
                acc_d[pick]   = '0;
                state_d[pick] = HOLD;
            end else begin
                acc_d[pick] = sum;
            end
            if (sum_ovf) begin
                ovf_d[pick] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                state_q[k] <= ACCUM;
                acc_q[k]   <= '0;
                res_q[k]   <= '0;
            end
            ovf_q <= '0;
            ptr_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        bus.res_valid = '0;
        bus.res_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            bus.res_valid[k]                 = (state_q[k] == HOLD);
            bus.res_data[k*O_VEC +: O_VEC] = res_q[k];
        end
        bus.gnt = gnt;
        bus.ovf = ovf_q;
    end

endmodule

// File: tb/tb_sm_acc_arbiter.sv
// Directed bench for sm_acc_arbiter: sums, cancellation, round-robin,
// hold/release, saturation and mid-sum reset.
module tb_sm_acc_arbiter;
    import sm_acc_arbiter_pkg::*;

    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    sm_acc_arbiter_if #(.NREQ(N)) bus ();

    sm_acc_arbiter #(.NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input int k);
        return 32'(bus.res_data[k*O_VEC +: O_VEC]);
    endfunction

    task automatic set_term(input int k, input logic [O_VEC-1:0] v,
                            input logic l);
        bus.term_data[k*O_VEC +: O_VEC] = v;
        bus.term_last[k]                = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req       = '0;
        bus.term_last = '0;
        bus.res_ready = '0;
        rst_n         = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        bus.term_data = '0;
        do_reset();

        @(negedge clk);
        check("rst_gnt",   32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.res_valid), 32'h0);
        check("rst_data0", rd(0), 32'h0);
        check("rst_data3", rd(3), 32'h0);
        check("rst_ovf",   32'(bus.ovf), 32'h0);

        // lane 0: +5, -3, +10 -> +12
        step();
        bus.req = 4'b0001;
        set_term(0, 21'h000005, 1'b0);
        @(negedge clk);
        check("l0_gnt_a", 32'(bus.gnt), 32'h1);
        step();
        set_term(0, 21'h100003, 1'b0);
        @(negedge clk);
        check("l0_gnt_b", 32'(bus.gnt), 32'h1);
        step();
        set_term(0, 21'h00000A, 1'b1);
        @(negedge clk);
        check("l0_gnt_c", 32'(bus.gnt), 32'h1);
        check("l0_valid_early", 32'(bus.res_valid), 32'h0);
        step();
        bus.req       = '0;
        bus.term_last = '0;
        @(negedge clk);
        check("l0_valid", 32'(bus.res_valid), 32'h1);
        check("l0_data", rd(0), 32'h00000C);
        bus.res_ready = 4'b0001;
        step();
        bus.res_ready = '0;
        @(negedge clk);
        check("l0_release", 32'(bus.res_valid), 32'h0);

        // lane 1: +7, -7 -> +0
        step();
        bus.req = 4'b0010;
        set_term(1, 21'h000007, 1'b0);
        @(negedge clk);
        check("l1_gnt_a", 32'(bus.gnt), 32'h2);
        step();
        set_term(1, 21'h100007, 1'b1);
        step();
        bus.req       = '0;
        bus.term_last = '0;
        @(negedge clk);
        check("l1_cancel", rd(1), 32'h000000);
        bus.res_ready = 4'b0010;
        step();
        bus.res_ready = '0;

        // lane 1: -9, +4 -> -5
        bus.req = 4'b0010;
        set_term(1, 21'h100009, 1'b0);
        step();
        set_term(1, 21'h000004, 1'b1);
        step();
        bus.req       = '0;
        bus.term_last = '0;
        @(negedge clk);
        check("l1_neg", rd(1), 32'h100005);
        bus.res_ready = 4'b0010;
        step();
        bus.res_ready = '0;

        // round-robin from reset, all lanes adding +1
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            set_term(k, 21'h000001, 1'b0);
        end
        for (int c = 0; c < 8; c++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (c % 4);
            @(negedge clk);
            check($sformatf("rr_%0d", c), 32'(bus.gnt), 32'(exp_g));
            step();
        end

        // lane 2 finishes with +3 on acc 2 and is held
        bus.req = 4'b0100;
        set_term(2, 21'h000003, 1'b1);
        @(negedge clk);
        check("l2_gnt", 32'(bus.gnt), 32'h4);
        step();
        @(negedge clk);
        check("l2_data", rd(2), 32'h000005);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("l2_hold_%0d", c), 32'(bus.gnt), 32'h0);
            step();
            @(negedge clk);
        end
        bus.res_ready = 4'b0100;
        #1;
        check("l2_rel_gnt", 32'(bus.gnt), 32'h0);
        check("l2_rel_valid", 32'(bus.res_valid), 32'h4);
        step();
        bus.res_ready = '0;
        @(negedge clk);
        check("l2_after_valid", 32'(bus.res_valid), 32'h0);
        check("l2_after_gnt", 32'(bus.gnt), 32'h4);
        bus.req       = '0;
        bus.term_last = '0;

        // magnitude overflow on lane 0
        do_reset();
        bus.req = 4'b0001;
        set_term(0, 21'h0FFFFF, 1'b0);
        step();
        set_term(0, 21'h000001, 1'b1);
        step();
        bus.req       = '0;
        bus.term_last = '0;
        @(negedge clk);
`ifdef SM_ACC_SAT_EN
        check("sat_data", rd(0), 32'h0FFFFF);
        check("sat_ovf", 32'(bus.ovf), 32'h1);
`else
        check("wrap_data", rd(0), 32'h000000);
        check("wrap_ovf", 32'(bus.ovf), 32'h0);
`endif
        bus.res_ready = 4'b0001;
        step();
        bus.res_ready = '0;
        @(negedge clk);
        check("ovf_clear", 32'(bus.ovf), 32'h0);

        // lane 0 holds a result, lane 3 mid-sum, then reset
        step();
        bus.req = 4'b0001;
        set_term(0, 21'h000002, 1'b1);
        step();
        bus.req = 4'b1000;
        set_term(0, 21'h000000, 1'b0);
        set_term(3, 21'h000006, 1'b0);
        @(negedge clk);
        check("l3_gnt", 32'(bus.gnt), 32'h8);
        check("l0_held", 32'(bus.res_valid), 32'h1);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        check("mid_rst_valid", 32'(bus.res_valid), 32'h0);
        check("mid_rst_data0", rd(0), 32'h0);
        step();
        rst_n = 1'b1;
        set_term(3, 21'h000004, 1'b1);
        @(negedge clk);
        check("l3_regnt", 32'(bus.gnt), 32'h8);
        step();
        bus.req       = '0;
        bus.term_last = '0;
        @(negedge clk);
        check("l3_data", rd(3), 32'h000004);
        check("l3_valid", 32'(bus.res_valid), 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sm_acc_arbiter.md
# sm_acc_arbiter

Round-robin arbiter and accumulation sequencer that shares one sign-magnitude adder among NREQ neuron lanes. Each lane streams sign-magnitude product terms; the block grants one term per cycle, adds it to that lane's private accumulator, and presents the finished sum on the lane's result port when the lane marks its last term. It sits between the per-neuron multiplier outputs and the activation stage.

## Interface
- O_VEC, 21, word width: bit O_VEC-1 is the sign, bits O_VEC-2:0 are the magnitude
- NREQ, 4, number of requesting lanes (2..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  lane k offers term_data[k]
- term_data  in  NREQ*O_VEC  lane k term at bits [k*O_VEC +: O_VEC]
- term_last  in  NREQ  term is the final term of lane k's sum
- gnt  out  NREQ  one-hot or zero, combinational; the term is consumed at the next clk edge
- res_valid  out  NREQ  lane k result held
- res_ready  in  NREQ  consumer accepts lane k result
- res_data  out  NREQ*O_VEC  lane k sum, registered
- ovf  out  NREQ  sticky magnitude-overflow flag for the current lane k result

## Operation
- Per-lane state: ACCUM (accepting terms), HOLD (result waiting). Reset puts every lane in ACCUM with acc = 0.
- Eligible lanes: req[k] & (state[k] == ACCUM).
- Arbitration: round-robin from pointer ptr (reset value 0). The first eligible lane at or after ptr, wrapping, is granted. On a grant to lane k, ptr becomes (k+1) mod NREQ. If no lane is eligible, ptr is unchanged.
- Granted term t for lane k: sum = sm_add(acc[k], t), using the shared sub-module.
  - last = 0: acc[k] <= sum.
  - last = 1: res_data[k] <= sum, acc[k] <= 0, state[k] <= HOLD.
- HOLD → ACCUM on the edge where res_valid[k] & res_ready[k]. The lane is eligible again from the following cycle, never in the release cycle.
- Sign-magnitude rules:
  - Same signs: magnitudes add and the sign is kept.
  - Differing signs: the larger magnitude minus the smaller, with the larger operand's sign.
  - Any zero-magnitude result is normalized to +0 before it is stored.
- ovf[k] is cleared when lane k enters ACCUM after a result is consumed, and at reset.

## Timing
- Reset values: gnt = 0, res_valid = 0, res_data = 0, ovf = 0, ptr = 0, all acc = 0.
- Throughput: one term per cycle across all lanes.
- Latency: res_valid[k] rises one cycle after the grant of the last term.
- gnt depends on the current req and state only. A requester drops req or presents its next term after seeing gnt at the edge.
- A single-term sum (first term has last = 1) gives res_data = term, normalized.
- Reset asserted mid-sum discards all accumulators and pending results immediately.

## Configuration
- SM_ACC_SAT_EN defined: a same-sign add whose magnitude carries out of O_VEC-1 bits clamps to the maximum magnitude (all ones) with the operands' sign. ovf[k] is set and stays set until that result is consumed.
- SM_ACC_SAT_EN undefined: the magnitude wraps modulo 2^(O_VEC-1), matching the plain adder, and ovf is tied to 0.

## Structure
- Shared package:
  - Word width constant.
  - Sign and magnitude index constants.
  - Lane state enum {ACCUM, HOLD}.
  - Maximum-magnitude constant.
- Sub-module sm_add_unit: combinational sign-magnitude add with carry-out, normalization to +0, and optional saturation. It is instantiated once and its operands are muxed by gnt.
- Round-robin pick, per-lane state, and accumulators stay in the top level.

## Test plan
- Lane 0 alone: terms +5 (0x000005), -3 (0x100003), +10 (0x00000A, last) → res_data[0] = 0x00000C. res_valid rises 1 cycle after the last grant.
- Cancellation: lane 1 terms +7, -7 (last) → res_data[1] = 0x000000, not 0x100000.
- All 4 lanes requesting continuously from reset → gnt sequence is 0,1,2,3,0,… with exactly one gnt bit set per cycle.
- Lane 2 in HOLD with res_ready = 0 while req[2] = 1 → lane 2 is never granted. Raise res_ready → res_valid drops next edge, and lane 2 is granted no earlier than the cycle after.
- With SM_ACC_SAT_EN: terms 0x0FFFFF, 0x000001 (last) → res_data = 0x0FFFFF and ovf = 1. Without the macro → 0x000000 and ovf = 0.
- rst_n pulsed low mid-sum on lane 3 → all outputs 0 immediately. A new sum of +4 (last) → res_data[3] = 0x000004.
